// File: rtl/somador_sequencial_if.sv
// Purpose: operand/result bundle between the requester and the sequential adder.
// Latency: none; plain wires grouped for port connection.
// Backpressure: start is only honoured while the adder is idle; busy shows when it is not.
interface somador_sequencial_if #(
  parameter int N = 8
);
  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/somador_sequencial.sv
// Purpose: N-bit add/subtract processed D bits per clock, LSB chunk first.
// Latency: done pulses N/D edges after the accepting edge; next start accepted two edges later.
// Backpressure: start is ignored (not queued) while busy or during the done cycle.
module somador_sequencial #(
  parameter int N = 8,
  parameter int D = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  somador_sequencial_if.slave bus
);

  localparam int STEPS = N / D;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : g_param_check
    $error("somador_sequencial: need N >= 2, 1 <= D <= N and N %% D == 0");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  op_a, op_b;   // remaining operand chunks, consumed from the LSB end
  logic          carry;        // carry between chunks (inverted borrow when subtracting)
  logic [N-1:0]  acc;          // partial result, filled from the MSB end
  logic [CW-1:0] cnt;
  logic [N-1:0]  s_q;
  logic          cout_q, ovf_q;

  logic [D:0]    chunk;
  logic          c_into_top;
  logic [N-1:0]  acc_nxt, op_a_shr, op_b_shr;
  logic          last;

  // Chunk adder plus the shifted views of the operand and result registers
  always_comb begin
    chunk      = {1'b0, op_a[D-1:0]} + {1'b0, op_b[D-1:0]} + {{D{1'b0}}, carry};
    // carry into the chunk's top bit, recovered from its sum bit; on the last
    // chunk this is the carry into bit N-1 used for signed overflow
    c_into_top = chunk[D-1] ^ op_a[D-1] ^ op_b[D-1];
    acc_nxt    = N'({chunk[D-1:0], acc} >> D);
    op_a_shr   = N'({{D{1'b0}}, op_a} >> D);
    op_b_shr   = N'({{D{1'b0}}, op_b} >> D);
    last       = (cnt == CW'(STEPS - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: one pass through CALC per accepted request
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Operand capture, chunk-serial accumulation and result load on the final chunk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // subtraction is a + ~b + ~borrow, so invert b and cin once here
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b   : bus.b;
            carry <= bus.sub ? ~bus.cin : bus.cin;
            cnt   <= '0;
          end
        end
        CALC: begin
          op_a  <= op_a_shr;
          op_b  <= op_b_shr;
          carry <= chunk[D];
          acc   <= acc_nxt;
          cnt   <= cnt + CW'(1);
          if (last) begin
            s_q    <= acc_nxt;
            cout_q <= chunk[D];
            ovf_q  <= chunk[D] ^ c_into_top;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == CALC);
  assign bus.done = (state == DONE);
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_somador_sequencial.sv
// Purpose: checks somador_sequencial at N=8 with D=1, 4 and 8 side by side.
// Latency: a reference model predicts every output each cycle; directed ops pin exact values.
// Backpressure: exercises start during CALC/DONE, start held high, and async reset mid-op.
module tb_somador_sequencial;

  localparam int N = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic         cin   = 1'b0;
  logic [N-1:0] a     = '0;
  logic [N-1:0] b     = '0;

  somador_sequencial_if #(.N(N)) if1 ();
  somador_sequencial_if #(.N(N)) if4 ();
  somador_sequencial_if #(.N(N)) if8 ();

  assign if1.start = start; assign if1.sub = sub; assign if1.cin = cin; assign if1.a = a; assign if1.b = b;
  assign if4.start = start; assign if4.sub = sub; assign if4.cin = cin; assign if4.a = a; assign if4.b = b;
  assign if8.start = start; assign if8.sub = sub; assign if8.cin = cin; assign if8.a = a; assign if8.b = b;

  somador_sequencial #(.N(N), .D(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  somador_sequencial #(.N(N), .D(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  somador_sequencial #(.N(N), .D(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  logic [2:0]   busy_v, done_v, cout_v, ovf_v;
  logic [N-1:0] s_v [3];
  assign busy_v = {if8.busy, if4.busy, if1.busy};
  assign done_v = {if8.done, if4.done, if1.done};
  assign cout_v = {if8.cout, if4.cout, if1.cout};
  assign ovf_v  = {if8.ovf,  if4.ovf,  if1.ovf};
  assign s_v[0] = if1.s;
  assign s_v[1] = if4.s;
  assign s_v[2] = if8.s;

  function automatic int steps_of(input int i);
    return (i == 0) ? 8 : (i == 1) ? 2 : 1;
  endfunction

  function automatic int d_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 8;
  endfunction

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [D=%0d] at %0t: got %0h, expected %0h", nm, d_of(idx), $time, act, exp);
    end
  endtask

  // Reference result: whole-word arithmetic, signed overflow from operand/result signs
  function automatic logic [N+1:0] ref_op(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic c, input logic sb);
    logic [N-1:0] yy;
    logic         cc;
    logic [N:0]   sum;
    logic         ov;
    yy  = sb ? ~y : y;
    cc  = sb ? ~c : c;
    sum = {1'b0, x} + {1'b0, yy} + {{N{1'b0}}, cc};
    ov  = (x[N-1] == yy[N-1]) && (sum[N-1] != x[N-1]);
    return {ov, sum};
  endfunction

  // Model: phase 0 idle, 1 computing (rem cycles left), 2 done cycle
  int           ph  [3];
  int           rem [3];
  logic [N-1:0] m_s [3], p_s [3];
  logic         m_c [3], m_o [3], p_c [3], p_o [3];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        ph[i] = 0; rem[i] = 0; m_s[i] = '0; m_c[i] = 1'b0; m_o[i] = 1'b0;
      end else begin
        case (ph[i])
          0: if (start) begin
            logic [N+1:0] r;
            r      = ref_op(a, b, cin, sub);
            p_s[i] = r[N-1:0];
            p_c[i] = r[N];
            p_o[i] = r[N+1];
            rem[i] = steps_of(i);
            ph[i]  = 1;
          end
          1: begin
            rem[i] = rem[i] - 1;
            if (rem[i] == 0) begin
              m_s[i] = p_s[i]; m_c[i] = p_c[i]; m_o[i] = p_o[i];
              ph[i]  = 2;
            end
          end
          default: ph[i] = 0;
        endcase
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("busy", i, busy_v[i], ph[i] == 1);
      chk("done", i, done_v[i], ph[i] == 2);
      chk("s",    i, s_v[i],    m_s[i]);
      chk("cout", i, cout_v[i], m_c[i]);
      chk("ovf",  i, ovf_v[i],  m_o[i]);
    end
  end

  // One op from idle; inputs scrambled after acceptance; done edge and result pinned by hand
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tc, input logic ts,
                        input logic [N-1:0] es, input logic ec, input logic eo);
    @(negedge clk); a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
    @(negedge clk); start = 1'b0; a = ~ta; b = ~tb_; cin = ~tc; sub = ~ts;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk("done_edge", i, done_v[i], j == steps_of(i));
        if (j == steps_of(i)) begin
          chk("lit_s",    i, s_v[i],    es);
          chk("lit_cout", i, cout_v[i], ec);
          chk("lit_ovf",  i, ovf_v[i],  eo);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int last_done [3];
  int n_done    [3];
  int exp_ndone [3] = '{4, 10, 13};

  initial begin
    // reset state
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", i, busy_v[i], 0);
      chk("rst_done", i, done_v[i], 0);
      chk("rst_s",    i, s_v[i],    0);
      chk("rst_cout", i, cout_v[i], 0);
      chk("rst_ovf",  i, ovf_v[i],  0);
    end
    rst_n = 1'b1;

    // directed arithmetic
    run_op(8'd200, 8'd100, 1'b1, 1'b0, 8'd45,  1'b1, 1'b0);
    run_op(8'd5,   8'd7,   1'b0, 1'b1, 8'hFE,  1'b0, 1'b0);
    run_op(8'h80,  8'd1,   1'b0, 1'b1, 8'h7F,  1'b1, 1'b1);
    run_op(8'd127, 8'd1,   1'b0, 1'b0, 8'd128, 1'b0, 1'b1);
    run_op(8'd255, 8'd1,   1'b0, 1'b0, 8'd0,   1'b1, 1'b0);
    run_op(8'd10,  8'd3,   1'b1, 1'b1, 8'd6,   1'b1, 1'b0);

    // start pulse with other operands while D=1 is still computing
    @(negedge clk); a = 8'd200; b = 8'd100; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    a = 8'd1; b = 8'd1; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int j = 4; j <= 8; j++) begin
      @(negedge clk);
      chk("pulse_done", 0, done_v[0], j == 8);
      if (j == 8) chk("pulse_s", 0, s_v[0], 8'd45);
    end
    repeat (12) @(negedge clk);

    // start held high: a new op every N/D+2 edges
    a = 8'd127; b = 8'd1; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin last_done[i] = -1; n_done[i] = 0; end
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) begin
          if (last_done[i] < 0) chk("held_first", i, j, steps_of(i));
          else                  chk("held_gap",   i, j - last_done[i], steps_of(i) + 2);
          last_done[i] = j;
          n_done[i]++;
        end
      end
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) chk("held_count", i, n_done[i], exp_ndone[i]);
    repeat (12) @(negedge clk);

    // asynchronous reset in the middle of CALC cycle 3
    a = 8'd200; b = 8'd100; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("arst_busy", i, busy_v[i], 0);
      chk("arst_done", i, done_v[i], 0);
      chk("arst_s",    i, s_v[i],    0);
      chk("arst_cout", i, cout_v[i], 0);
      chk("arst_ovf",  i, ovf_v[i],  0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("arst_nodone", 0, done_v[0], 0);
    end
    run_op(8'd200, 8'd100, 1'b1, 1'b0, 8'd45, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
